// File: rtl/mont_modexp_param.sv
// Montgomery modular exponentiator: result = base^exponent mod modulus (odd modulus).
// One shared bit-serial Montgomery multiplier, on-chip R^2 mod M, LSB-first exponent scan.
module mont_modexp_param #(
    parameter int WIDTH      = 32,
    parameter int EXP_WIDTH  = 32,
    parameter int CONST_TIME = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result
);

    localparam int   CW = $clog2(2 * WIDTH);
    localparam int   BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic CT = (CONST_TIME != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_R2, S_TO_MONT, S_EXP, S_FROM_MONT, S_DONE
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     x_q, m_q, t_q, z_q, p_q, a_q, b_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic [WIDTH+1:0]     s_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_q;
    logic                 ph_q;

    logic [WIDTH+1:0]     mm_sum, mm_step;
    logic [WIDTH-1:0]     mm_res, t_next;
    logic [WIDTH:0]       t_dbl;
    logic [EXP_WIDTH-1:0] e_nxt;
    logic                 mm_active, mm_last, mul_nxt;

    // S stays below 2M, so S + B + M < 4M fits in WIDTH+2 bits.
    always_comb begin
        mm_sum    = s_q + (a_q[0] ? {2'b00, b_q} : '0);
        mm_step   = (mm_sum + (mm_sum[0] ? {2'b00, m_q} : '0)) >> 1;
        mm_res    = WIDTH'((s_q >= {2'b00, m_q}) ? s_q - {2'b00, m_q} : s_q);
        t_dbl     = {t_q, 1'b0};
        t_next    = (t_dbl >= {1'b0, m_q}) ? WIDTH'(t_dbl - {1'b0, m_q}) : t_dbl[WIDTH-1:0];
        e_nxt     = e_q >> 1;
        mul_nxt   = e_nxt[0] | CT;
        mm_active = (state_q == S_TO_MONT) || (state_q == S_EXP) || (state_q == S_FROM_MONT);
        mm_last   = (cnt_q == CW'(WIDTH));
    end

    // NOTE: every register, datapath included, is cleared by reset so an aborted
    // operation leaves nothing behind; all state updates use non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            m_q     <= '0;
            t_q     <= '0;
            z_q     <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            e_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            ph_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (mm_active && !mm_last) begin
                s_q   <= mm_step;
                a_q   <= a_q >> 1;
                cnt_q <= cnt_q + CW'(1);
            end
            case (state_q)
                S_IDLE: if (start) begin
                    x_q     <= base;
                    e_q     <= exponent;
                    m_q     <= modulus;
                    busy    <= 1'b1;
                    error   <= 1'b0;
                    result  <= '0;
                    state_q <= S_CHECK;
                end
                S_CHECK: if (!m_q[0]) begin
                    error   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    t_q     <= (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    cnt_q   <= '0;
                    state_q <= S_R2;
                end
                S_R2: begin
                    t_q <= t_next;
                    if (cnt_q == CW'(2 * WIDTH - 1)) begin
                        cnt_q   <= '0;
                        s_q     <= '0;
                        a_q     <= WIDTH'(1);
                        b_q     <= t_next;
                        ph_q    <= 1'b0;
                        state_q <= S_TO_MONT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_TO_MONT: if (mm_last) begin
                    cnt_q <= '0;
                    s_q   <= '0;
                    if (!ph_q) begin
                        z_q  <= mm_res;
                        a_q  <= x_q;
                        b_q  <= t_q;
                        ph_q <= 1'b1;
                    end else begin
                        p_q     <= mm_res;
                        bit_q   <= '0;
                        ph_q    <= !(e_q[0] | CT);
                        a_q     <= mm_res;
                        b_q     <= (e_q[0] | CT) ? z_q : mm_res;
                        state_q <= S_EXP;
                    end
                end
                // ph_q = 0: multiply step, ph_q = 1: squaring step.
                S_EXP: if (mm_last) begin
                    cnt_q <= '0;
                    s_q   <= '0;
                    if (!ph_q) begin
                        if (e_q[0]) z_q <= mm_res;
                        ph_q <= 1'b1;
                        a_q  <= p_q;
                        b_q  <= p_q;
                    end else begin
                        p_q <= mm_res;
                        e_q <= e_nxt;
                        if (bit_q == BW'(EXP_WIDTH - 1)) begin
                            bit_q   <= '0;
                            a_q     <= z_q;
                            b_q     <= WIDTH'(1);
                            state_q <= S_FROM_MONT;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                            ph_q  <= !mul_nxt;
                            a_q   <= mm_res;
                            b_q   <= mul_nxt ? z_q : mm_res;
                        end
                    end
                end
                S_FROM_MONT: if (mm_last) begin
                    cnt_q   <= '0;
                    s_q     <= '0;
                    result  <= mm_res;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_modexp_param.sv
// Scoreboard bench for mont_modexp_param: a constant-time and a variable-time
// instance (WIDTH=8, EXP_WIDTH=8) driven with directed and golden-model vectors.
module tb_mont_modexp_param;

    localparam int W        = 8;
    localparam int EW       = 8;
    localparam int MM       = W + 1;
    localparam int LAT_BASE = 1 + 2 * W + 3 * MM + EW * MM;
    localparam int LIMIT    = 3000;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic [W-1:0]  base = '0, modulus = '0;
    logic [EW-1:0] exponent = '0;
    logic          busy_a, done_a, error_a, busy_b, done_b, error_b;
    logic [W-1:0]  result_a, result_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t it_a, it_b;

    mont_modexp_param #(.WIDTH(W), .EXP_WIDTH(EW), .CONST_TIME(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base(base), .exponent(exponent),
        .modulus(modulus), .busy(busy_a), .done(done_a), .error(error_a), .result(result_a)
    );

    mont_modexp_param #(.WIDTH(W), .EXP_WIDTH(EW), .CONST_TIME(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base(base), .exponent(exponent),
        .modulus(modulus), .busy(busy_b), .done(done_b), .error(error_b), .result(result_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] golden(input logic [W-1:0] x, input logic [EW-1:0] e,
                                            input logic [W-1:0] m);
        int unsigned r, b;
        r = 1 % int'(m);
        b = int'(x) % int'(m);
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * b) % int'(m);
            b = (b * b) % int'(m);
        end
        return W'(r);
    endfunction

    // Scoreboard monitors: one per instance, compare on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done_a) begin
            if (q_a.size() == 0) begin
                check("spurious_done_a", 32'(done_a), 32'd0);
            end else begin
                it_a = q_a.pop_front();
                check("result_a", 32'(result_a), 32'(it_a.res));
                check("error_a", 32'(error_a), 32'(it_a.err));
                check("latency_a", 32'(cyc - it_a.acc), 32'(it_a.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done_b) begin
            if (q_b.size() == 0) begin
                check("spurious_done_b", 32'(done_b), 32'd0);
            end else begin
                it_b = q_b.pop_front();
                check("result_b", 32'(result_b), 32'(it_b.res));
                check("error_b", 32'(error_b), 32'(it_b.err));
                check("latency_b", 32'(cyc - it_b.acc), 32'(it_b.lat));
            end
        end
    end

    task automatic issue(input bit which, input logic [W-1:0] x, input logic [EW-1:0] e,
                         input logic [W-1:0] m, input logic [W-1:0] r, input logic er);
        exp_t it;
        int   lat;
        if (er)         lat = 1;
        else if (!which) lat = LAT_BASE + EW * MM;
        else            lat = LAT_BASE + $countones(e) * MM;
        @(negedge clk);
        base = x;
        exponent = e;
        modulus = m;
        it = '{res: r, err: er, lat: lat, acc: cyc + 1};
        if (which) begin q_b.push_back(it); start_b = 1'b1; end
        else       begin q_a.push_back(it); start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic finish_op(input bit which);
        int n = 0;
        while (((which ? q_b.size() : q_a.size()) != 0) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL timeout on instance %0d: no done within %0d cycles", which, LIMIT);
            if (which) q_b.delete(); else q_a.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input bit which, input logic [W-1:0] x, input logic [EW-1:0] e,
                       input logic [W-1:0] m, input logic [W-1:0] r, input logic er);
        issue(which, x, e, m, r, er);
        finish_op(which);
    endtask

    initial begin
        logic [W-1:0]  rx, rm;
        logic [EW-1:0] re;
        int            n;

        repeat (3) @(negedge clk);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_out_b", 32'({busy_b, done_b, error_b, result_b}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reference vector on both instances.
        run(0, 8'd4, 8'd13, 8'd187, 8'd174, 1'b0);
        run(1, 8'd4, 8'd13, 8'd187, 8'd174, 1'b0);

        // Boundaries and hand-computed vectors.
        run(1, 8'd200, 8'd1,   8'd187, 8'd13,  1'b0);
        run(1, 8'd77,  8'd0,   8'd187, 8'd1,   1'b0);
        run(1, 8'd77,  8'd0,   8'd1,   8'd0,   1'b0);
        run(0, 8'd0,   8'd5,   8'd187, 8'd0,   1'b0);
        run(0, 8'd3,   8'd5,   8'd7,   8'd5,   1'b0);
        run(1, 8'd2,   8'd10,  8'd255, 8'd4,   1'b0);
        run(1, 8'd2,   8'd255, 8'd3,   8'd2,   1'b0);
        run(0, 8'd255, 8'd3,   8'd187, 8'd85,  1'b0);
        run(1, 8'd7,   8'd2,   8'd13,  8'd10,  1'b0);

        // Even modulus, including zero.
        run(0, 8'd4, 8'd13, 8'd186, 8'd0, 1'b1);
        run(1, 8'd4, 8'd13, 8'd0,   8'd0, 1'b1);

        // Start while busy is ignored.
        issue(0, 8'd4, 8'd13, 8'd187, 8'd174, 1'b0);
        repeat (50) @(negedge clk);
        base = 8'd9;
        exponent = 8'd3;
        modulus = 8'd101;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("busy_during_op", 32'(busy_a), 32'd1);
        finish_op(0);

        // Start held during the done cycle is ignored.
        issue(1, 8'd3, 8'd5, 8'd7, 8'd5, 1'b0);
        n = 0;
        while (!done_b && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done_b");
        end
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        check("busy_after_done_start", 32'(busy_b), 32'd0);
        repeat (3) @(negedge clk);
        check("idle_after_done_start", 32'(busy_b), 32'd0);
        finish_op(1);

        // Reset in the middle of the exponent loop aborts without done.
        issue(0, 8'd4, 8'd13, 8'd187, 8'd174, 1'b0);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done_err_res", 32'({done_a, error_a, result_a}), 32'd0);
        q_a.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (250) @(negedge clk);
        check("abort_idle", 32'(busy_a), 32'd0);
        run(0, 8'd4, 8'd13, 8'd187, 8'd174, 1'b0);

        // Sweep against the golden model.
        for (int i = 0; i < 10; i++) begin
            rx = W'($urandom_range(0, 255));
            re = EW'($urandom_range(0, 255));
            rm = W'($urandom_range(0, 127) * 2 + 1);
            run(i[0], rx, re, rm, golden(rx, re, rm), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
